// File: rtl/move_sched.sv
// move_sched: paces snake moves at a difficulty-dependent rate and runs a
// req/done handshake with the snake datapath, guarded by a timeout.
// Ports: clk, reset (async, active-low); game_state, SW (difficulty),
// BTN (direction), move_done in; move_req, dir, level, move_count,
// timeout_err out.
module move_sched #(
  parameter int unsigned DIV_EASY = 25000000,
  parameter int unsigned DIV_MED  = 12500000,
  parameter int unsigned DIV_HARD = 6250000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  game_state,
  input  logic [2:0]  SW,
  input  logic [3:0]  BTN,
  input  logic        move_done,
  output logic        move_req,
  output logic [1:0]  dir,
  output logic [1:0]  level,
  output logic [15:0] move_count,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    REQ,
    WAIT_DONE
  } state_t;

  localparam logic [31:0] DIV_E_LAST = 32'(DIV_EASY - 1);
  localparam logic [31:0] DIV_M_LAST = 32'(DIV_MED - 1);
  localparam logic [31:0] DIV_H_LAST = 32'(DIV_HARD - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);

  localparam logic [1:0] GS_START = 2'b00;
  localparam logic [1:0] GS_PAUSE = 2'b01;
  localparam logic [1:0] GS_OVER  = 2'b10;
  localparam logic [1:0] GS_PLAY  = 2'b11;

  state_t      state;
  state_t      state_nx;
  logic [31:0] div_cnt;
  logic [31:0] div_nx;
  logic [31:0] wait_cnt;
  logic [31:0] wait_nx;
  logic [31:0] div_last;
  logic [1:0]  next_dir;
  logic [1:0]  next_dir_nx;
  logic [1:0]  dir_nx;
  logic [1:0]  level_nx;
  logic [1:0]  sw_level;
  logic [1:0]  btn_dir;
  logic        btn_hit;
  logic [15:0] count_nx;
  logic        terr_nx;

  assign move_req = (state == REQ) || (state == WAIT_DONE);

  always_comb begin
    sw_level = 2'b00;
    priority case (1'b1)
      SW[2]:   sw_level = 2'b10;
      SW[1]:   sw_level = 2'b01;
      SW[0]:   sw_level = 2'b00;
      default: sw_level = 2'b00;
    endcase
  end

  // Button index equals its direction code.
  always_comb begin
    btn_hit = 1'b1;
    btn_dir = 2'b11;
    priority case (1'b1)
      BTN[0]:  btn_dir = 2'b00;
      BTN[1]:  btn_dir = 2'b01;
      BTN[2]:  btn_dir = 2'b10;
      BTN[3]:  btn_dir = 2'b11;
      default: btn_hit = 1'b0;
    endcase
  end

  always_comb begin
    div_last = DIV_E_LAST;
    unique case (level)
      2'b01:   div_last = DIV_M_LAST;
      2'b10:   div_last = DIV_H_LAST;
      default: div_last = DIV_E_LAST;
    endcase
  end

  always_comb begin
    state_nx    = state;
    div_nx      = div_cnt;
    wait_nx     = wait_cnt;
    dir_nx      = dir;
    next_dir_nx = next_dir;
    level_nx    = level;
    count_nx    = move_count;
    terr_nx     = timeout_err;

    // Reversal is judged against the committed direction.
    if (game_state != GS_OVER && btn_hit &&
        btn_dir != (dir ^ 2'b01)) begin
      next_dir_nx = btn_dir;
    end

    unique case (state)
      IDLE: begin
        if (game_state == GS_PLAY) begin
          state_nx = WAIT_TICK;
          level_nx = sw_level;
        end
      end
      WAIT_TICK: begin
        unique case (game_state)
          GS_PLAY: begin
            if (div_cnt == div_last) begin
              div_nx   = '0;
              state_nx = REQ;
              // dir changes together with the rising move_req
              dir_nx   = next_dir;
            end else begin
              div_nx = div_cnt + 32'd1;
            end
          end
          GS_PAUSE: begin
            div_nx = div_cnt;
          end
          default: begin
            div_nx   = '0;
            state_nx = IDLE;
          end
        endcase
      end
      REQ: begin
        wait_nx  = '0;
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (move_done || wait_cnt == TO_LAST) begin
          if (move_done) begin
            if (move_count != 16'hFFFF) begin
              count_nx = move_count + 16'd1;
            end
          end else begin
            terr_nx = 1'b1;
          end
          wait_nx = '0;
          // playing or paused both keep the game alive
          state_nx = game_state[0] ? WAIT_TICK : IDLE;
        end else begin
          wait_nx = wait_cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx == IDLE && game_state == GS_START) begin
      dir_nx      = 2'b11;
      next_dir_nx = 2'b11;
      count_nx    = '0;
      terr_nx     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      wait_cnt    <= '0;
      dir         <= 2'b11;
      next_dir    <= 2'b11;
      level       <= 2'b00;
      move_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      div_cnt     <= div_nx;
      wait_cnt    <= wait_nx;
      dir         <= dir_nx;
      next_dir    <= next_dir_nx;
      level       <= level_nx;
      move_count  <= count_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: doc/move_sched.md
MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 SHALL have parameter DIV_EASY, 25000000, clk cycles per move at easy level.
REQ-002 SHALL have parameter DIV_MED, 12500000, clk cycles per move at medium level.
REQ-003 SHALL have parameter DIV_HARD, 6250000, clk cycles per move at hard level.
REQ-004 SHALL have parameter TIMEOUT, 1024, max clk cycles to wait for move_done.
REQ-005 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-007 SHALL have port game_state, input, 2; 00 start, 01 pause, 10 over, 11 playing.
REQ-008 SHALL have port SW, input, 3; difficulty select, [0] easy, [1] medium, [2] hard.
REQ-009 SHALL have port BTN, input, 4; direction, [0] up, [1] down, [2] left, [3] right.
REQ-010 SHALL have port move_done, input, 1; snake datapath has finished the requested step.
REQ-011 SHALL have port move_req, output, 1; request one step of the snake datapath.
REQ-012 SHALL have port dir, output, 2; committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-013 SHALL have port level, output, 2; latched difficulty: 00 easy, 01 medium, 10 hard.
REQ-014 SHALL have port move_count, output, 16; steps completed in the current game.
REQ-015 SHALL have port timeout_err, output, 1; sticky flag, a step was not acknowledged in time.

Function
REQ-016 SHALL have FSM states IDLE, WAIT_TICK, REQ, WAIT_DONE.
REQ-017 IDLE -> WAIT_TICK when game_state==11; latch level on this transition; SW[2] beats SW[1] beats SW[0]; no SW set -> easy.
REQ-018 WAIT_TICK: 32-bit divider counts 0..DIV_level-1; when the counter equals DIV_level-1 it SHALL clear and go to REQ.
REQ-019 WAIT_TICK with game_state==01 SHALL freeze the divider (no clear) and not advance.
REQ-020 WAIT_TICK with game_state 00 or 10 SHALL go to IDLE and clear the divider.
REQ-021 REQ: assert move_req; load dir <= next_dir in the same cycle; go to WAIT_DONE.
REQ-022 WAIT_DONE: hold move_req high until move_done is sampled high; the step SHALL never be abandoned because game_state changed.
REQ-023 move_done sampled high in WAIT_DONE SHALL deassert move_req next cycle and increment move_count, which saturates at 16'hFFFF.
REQ-024 After move_done, next state SHALL be: WAIT_TICK if game_state is 11 or 01; IDLE otherwise.
REQ-025 move_done outside WAIT_DONE SHALL be ignored.
REQ-026 A wait counter SHALL count the cycles spent in WAIT_DONE; at TIMEOUT cycles without move_done: set timeout_err, drop move_req, do not increment move_count, and go to WAIT_TICK (or IDLE per REQ-024).
REQ-027 next_dir register: in any state except while game_state==10, a high BTN bit SHALL load its direction; priority BTN[0] > BTN[1] > BTN[2] > BTN[3].
REQ-028 A BTN direction that is the reverse of the current dir (up/down, left/right) SHALL be ignored.
REQ-029 Entering IDLE from game_state==00 (new game) SHALL set dir and next_dir to right (11), clear move_count, and clear timeout_err.
REQ-030 Move period SHALL be exactly DIV_level + 2 cycles, rising edge of move_req to next rising edge, when move_done returns the cycle after move_req rises.
REQ-031 level SHALL be stable from latch until the next IDLE -> WAIT_TICK transition; SW changes mid-game SHALL be ignored.

Reset
REQ-032 reset low SHALL immediately set: state IDLE, divider 0, wait counter 0, move_req 0, dir 11, next_dir 11, level 00, move_count 0, timeout_err 0.
REQ-033 reset asserted mid-handshake SHALL drop move_req asynchronously; after release the block SHALL start from IDLE.

Verification (DIV_EASY=8, DIV_MED=4, DIV_HARD=2, TIMEOUT=16)
REQ-034 SW=110, game_state=11, move_done one cycle after each req -> level=10, move_req rises every 4 cycles, move_count increments by 1 per step.
REQ-035 dir=11, pulse BTN[2] then BTN[0] -> BTN[2] ignored (reversal), dir becomes 00 at the next move_req.
REQ-036 game_state 11 -> 01 for 20 cycles, then back to 11 -> no move_req during pause; divider resumes from its frozen value.
REQ-037 Hold move_done low after move_req -> move_req drops after 16 cycles, timeout_err=1, move_count unchanged.
REQ-038 game_state -> 10 while in WAIT_DONE -> move_req held until move_done, then IDLE; then game_state=00 -> move_count=0, dir=11.
REQ-039 reset low during WAIT_DONE -> move_req=0 in the same cycle, all outputs at their REQ-032 values.
